// File: rtl/sha1_pkg.sv
// sha1_pkg: shared constants, encodings and FSM states for the SHA-1 round sequencer.
package sha1_pkg;
    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hefcdab89;
    localparam logic [31:0] IV2 = 32'h98badcfe;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hc3d2e1f0;
    localparam logic [31:0] K0 = 32'h5a827999;
    localparam logic [31:0] K1 = 32'h6ed9eba1;
    localparam logic [31:0] K2 = 32'h8f1bbcdc;
    localparam logic [31:0] K3 = 32'hca62c1d6;
    typedef enum logic [1:0] {F_CH = 2'd0, F_PAR0 = 2'd1, F_MAJ = 2'd2, F_PAR1 = 2'd3} fsel_t;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_ROUND, S_FINAL, S_DONE} state_t;
    function automatic fsel_t fsel_of(input logic [6:0] t);
        return t < 7'd20 ? F_CH : t < 7'd40 ? F_PAR0 : t < 7'd60 ? F_MAJ : F_PAR1;
    endfunction
    function automatic logic [31:0] k_of(input fsel_t f);
        return f == F_CH ? K0 : f == F_PAR0 ? K1 : f == F_MAJ ? K2 : K3;
    endfunction
endpackage

// File: rtl/sha1_msg_sched.sv
// sha1_msg_sched: 16-word circular buffer that holds the block and expands W_t in place.
module sha1_msg_sched #(
    parameter int TW = 7
) (
    input  logic          clk,
    input  logic          load,
    input  logic [31:0]   load_word,
    input  logic          step,
    input  logic [TW-1:0] t,
    output logic [31:0]   w
);
    logic [31:0] mem_q [16];
    logic [3:0]  i;
    logic [31:0] x;
    assign i = t[3:0];
    // slot i still holds W[t-16] until it is overwritten with W[t] at this edge
    assign x = mem_q[i - 4'd3] ^ mem_q[i - 4'd8] ^ mem_q[i - 4'd14] ^ mem_q[i];
    assign w = (t < TW'(16)) ? mem_q[i] : {x[30:0], x[31]};
    always_ff @(posedge clk) begin
        if (load)
            mem_q[i] <= load_word;
        else if (step && t >= TW'(16))
            mem_q[i] <= w;
    end
endmodule

// File: rtl/sha1_round_ctrl.sv
// sha1_round_ctrl: block loader, round sequencer and chaining-value update for SHA-1.
module sha1_round_ctrl
    import sha1_pkg::*;
#(
    parameter int NUM_ROUNDS = 80,
    parameter int WORD_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              first_block,
    input  logic              msg_valid,
    output logic              msg_ready,
    input  logic [WORD_W-1:0] msg_word,
    output logic              feed,
    output logic              next,
    output logic [WORD_W-1:0] w,
    output logic [WORD_W-1:0] k,
    output logic [1:0]        fsel,
    output logic [WORD_W-1:0] ia,
    output logic [WORD_W-1:0] ib,
    output logic [WORD_W-1:0] ic,
    output logic [WORD_W-1:0] id,
    output logic [WORD_W-1:0] ie,
    input  logic [WORD_W-1:0] st_a,
    input  logic [WORD_W-1:0] st_b,
    input  logic [WORD_W-1:0] st_c,
    input  logic [WORD_W-1:0] st_d,
    input  logic [WORD_W-1:0] st_e,
    output logic [WORD_W-1:0] h0,
    output logic [WORD_W-1:0] h1,
    output logic [WORD_W-1:0] h2,
    output logic [WORD_W-1:0] h3,
    output logic [WORD_W-1:0] h4,
    output logic              busy,
    output logic              done
);
    localparam int TW = $clog2(NUM_ROUNDS);
    state_t            state_q;
    logic [TW-1:0]     t_q;
    logic [WORD_W-1:0] h_q [5];
    logic [31:0]       w_raw;
    fsel_t             f;
    // t_q doubles as the LOAD word index and the round counter
    sha1_msg_sched #(.TW(TW)) u_sched (
        .clk       (clk),
        .load      (msg_ready && msg_valid),
        .load_word (msg_word),
        .step      (next),
        .t         (t_q),
        .w         (w_raw)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            h_q     <= '{default: '0};
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_LOAD;
                    t_q     <= '0;
                    if (first_block) h_q <= '{IV0, IV1, IV2, IV3, IV4};
                end
                S_LOAD: if (msg_valid) begin
                    t_q <= (t_q == TW'(15)) ? '0 : t_q + 1'b1;
                    if (t_q == TW'(15)) state_q <= S_FEED;
                end
                S_FEED: state_q <= S_ROUND;
                S_ROUND: begin
                    t_q <= (t_q == TW'(NUM_ROUNDS - 1)) ? '0 : t_q + 1'b1;
                    if (t_q == TW'(NUM_ROUNDS - 1)) state_q <= S_FINAL;
                end
                S_FINAL: begin
                    h_q[0]  <= h_q[0] + st_a;
                    h_q[1]  <= h_q[1] + st_b;
                    h_q[2]  <= h_q[2] + st_c;
                    h_q[3]  <= h_q[3] + st_d;
                    h_q[4]  <= h_q[4] + st_e;
                    state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign msg_ready = state_q == S_LOAD;
    assign feed      = state_q == S_FEED;
    assign next      = state_q == S_ROUND;
    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign f         = fsel_of(7'(t_q));
    assign fsel      = next ? f : F_CH;
    assign k         = next ? k_of(f) : '0;
    assign w         = next ? w_raw : '0;
    assign {ia, ib, ic, id, ie} = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
    assign {h0, h1, h2, h3, h4} = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
endmodule

// File: tb/tb_sha1_round_ctrl.sv
// tb_sha1_round_ctrl: drives streamed blocks through the sequencer with a behavioural
// round unit attached and checks every round and digest against a plain SHA-1 model.
module tb_sha1_round_ctrl;
    logic clk = 0, reset, start, first_block, msg_valid;
    logic [31:0] msg_word;
    logic msg_ready, feed, next, busy, done;
    logic [31:0] w, k, ia, ib, ic, id, ie, h0, h1, h2, h3, h4;
    logic [1:0] fsel;
    logic [31:0] ra = 0, rb = 0, rc = 0, rd = 0, re = 0, na, nb, nc, nd, ne;
    int cyc = 0, n_checks = 0, n_fail = 0, lat;
    logic [31:0] blk [16];
    logic [31:0] rw [80];
    logic [31:0] mh [5];
    logic [31:0] hs [5];
    logic [31:0] he [5];
    localparam logic [31:0] IVR [5] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha1_round_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .first_block(first_block),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_word(msg_word),
        .feed(feed), .next(next), .w(w), .k(k), .fsel(fsel),
        .ia(ia), .ib(ib), .ic(ic), .id(id), .ie(ie),
        .st_a(ra), .st_b(rb), .st_c(rc), .st_d(rd), .st_e(re),
        .h0(h0), .h1(h1), .h2(h2), .h3(h3), .h4(h4), .busy(busy), .done(done)
    );

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction
    function automatic logic [31:0] f_of(input int sel, input logic [31:0] b, c, d);
        if (sel == 0) return (b & c) | (~b & d);
        if (sel == 2) return (b & c) | (b & d) | (c & d);
        return b ^ c ^ d;
    endfunction
    function automatic logic [31:0] kexp(input int t);
        return t < 20 ? 32'h5a827999 : t < 40 ? 32'h6ed9eba1 : t < 60 ? 32'h8f1bbcdc : 32'hca62c1d6;
    endfunction

    // round unit stand-in: decide at negedge, commit at posedge
    always @(negedge clk) begin
        {na, nb, nc, nd, ne} = {ra, rb, rc, rd, re};
        if (feed) {na, nb, nc, nd, ne} = {ia, ib, ic, id, ie};
        else if (next) begin
            na = rotl(ra, 5) + f_of(int'(fsel), rb, rc, rd) + re + k + w;
            {nb, nc, nd, ne} = {ra, rotl(rb, 30), rc, rd};
        end
    end
    always @(posedge clk) {ra, rb, rc, rd, re} <= {na, nb, nc, nd, ne};

    task automatic model_block(input bit fb);
        logic [31:0] a, b, c, d, e, tmp;
        for (int i = 0; i < 5; i++) hs[i] = fb ? IVR[i] : mh[i];
        for (int t = 0; t < 80; t++)
            if (t < 16) rw[t] = blk[t];
            else rw[t] = rotl(rw[t-3] ^ rw[t-8] ^ rw[t-14] ^ rw[t-16], 1);
        {a, b, c, d, e} = {hs[0], hs[1], hs[2], hs[3], hs[4]};
        for (int t = 0; t < 80; t++) begin
            tmp = rotl(a, 5) + f_of(t / 20 == 3 ? 1 : t / 20, b, c, d) + e + kexp(t) + rw[t];
            {e, d, c, b, a} = {d, c, rotl(b, 30), a, tmp};
        end
        he[0] = hs[0] + a; he[1] = hs[1] + b; he[2] = hs[2] + c; he[3] = hs[3] + d; he[4] = hs[4] + e;
    endtask

    task automatic run_block(input bit fb, input int stall, input int abort_at, input bit poke, input int exp_lat);
        int c0, wi, rt, nfeed, guard;
        bit fin;
        model_block(fb);
        msg_valid = 0;
        @(negedge clk); start = 1; first_block = fb;
        @(negedge clk); c0 = cyc;
        wi = 0; rt = 0; nfeed = 0; guard = 0; fin = 0;
        while (!fin && guard < 400) begin
            start = 0; first_block = 0;
            msg_valid = msg_ready && wi < 16 &&
                (stall == 0 || (stall == 1 && (cyc - c0) % 2 == 0) || (stall == 2 && $urandom_range(1) == 1));
            msg_word = $urandom;
            if (msg_valid) begin msg_word = blk[wi]; wi++; end
            n_checks++;
            if (feed && next) begin n_fail++; $display("FAIL feed_next_overlap: both high at cycle %0d", cyc - c0 + 1); end
            if (!done) begin
                n_checks++;
                if ({h0, h1, h2, h3, h4} !== {hs[0], hs[1], hs[2], hs[3], hs[4]}) begin
                    n_fail++; $display("FAIL h_stable: got %h expected %h", {h0, h1, h2, h3, h4}, {hs[0], hs[1], hs[2], hs[3], hs[4]});
                end
            end
            if (feed) begin
                nfeed++; n_checks++;
                if ({ia, ib, ic, id, ie} !== {hs[0], hs[1], hs[2], hs[3], hs[4]}) begin
                    n_fail++; $display("FAIL feed_ia_ie: got %h expected %h", {ia, ib, ic, id, ie}, {hs[0], hs[1], hs[2], hs[3], hs[4]});
                end
            end
            if (next) begin
                if (rt == abort_at) begin
                    reset = 1; msg_valid = 0;
                    @(negedge clk); reset = 0;
                    n_checks++;
                    if ({msg_ready, feed, next, busy, done} !== 5'b0 || w !== 0 || k !== 0 || fsel !== 0 || {h0, h1, h2, h3, h4} !== 160'b0) begin
                        n_fail++; $display("FAIL mid_reset: flags %b w %h k %h fsel %0d h %h, expected all zero",
                            {msg_ready, feed, next, busy, done}, w, k, fsel, {h0, h1, h2, h3, h4});
                    end
                    mh = '{default: 32'h0};
                    return;
                end
                n_checks++;
                if (rt >= 80) begin n_fail++; $display("FAIL next_overrun: next still high at round %0d expected 80 rounds", rt); end
                else begin
                    if (w !== rw[rt]) begin n_fail++; $display("FAIL w_t: t=%0d got %h expected %h", rt, w, rw[rt]); end
                    n_checks++;
                    if (k !== kexp(rt)) begin n_fail++; $display("FAIL k_t: t=%0d got %h expected %h", rt, k, kexp(rt)); end
                    n_checks++;
                    if (int'(fsel) != rt / 20) begin n_fail++; $display("FAIL fsel_t: t=%0d got %0d expected %0d", rt, fsel, rt / 20); end
                end
                if (poke) begin
                    msg_valid = 1; msg_word = $urandom;
                    if (rt == 10) begin start = 1; first_block = 1; end
                end
                rt++;
            end else begin
                n_checks++;
                if (w !== 0 || k !== 0 || fsel !== 0) begin
                    n_fail++; $display("FAIL wkf_outside_round: w %h k %h fsel %0d expected 0", w, k, fsel);
                end
            end
            if (done) fin = 1;
            else begin @(negedge clk); guard++; end
        end
        msg_valid = 0;
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL done_timeout: no done within %0d cycles", guard); return; end
        lat = cyc - c0 + 1;
        n_checks++;
        if (nfeed != 1) begin n_fail++; $display("FAIL feed_count: got %0d expected 1", nfeed); end
        n_checks++;
        if (rt != 80) begin n_fail++; $display("FAIL next_count: got %0d expected 80", rt); end
        if (exp_lat > 0) begin
            n_checks++;
            if (lat != exp_lat) begin n_fail++; $display("FAIL latency: done in cycle %0d expected %0d", lat, exp_lat); end
        end
        n_checks++;
        if ({h0, h1, h2, h3, h4} !== {he[0], he[1], he[2], he[3], he[4]}) begin
            n_fail++; $display("FAIL digest_model: got %h expected %h", {h0, h1, h2, h3, h4}, {he[0], he[1], he[2], he[3], he[4]});
        end
        mh = he;
        if (poke) begin start = 1; first_block = 1; end
        @(negedge clk); start = 0; first_block = 0;
        n_checks++;
        if (done !== 0 || busy !== 0 || {h0, h1, h2, h3, h4} !== {he[0], he[1], he[2], he[3], he[4]}) begin
            n_fail++; $display("FAIL after_done: done %b busy %b h %h, expected 0 0 %h", done, busy, {h0, h1, h2, h3, h4},
                {he[0], he[1], he[2], he[3], he[4]});
        end
    endtask

    task automatic set_abc;
        blk = '{default: 32'h0};
        blk[0] = 32'h61626380; blk[15] = 32'h00000018;
    endtask

    task automatic check_abc_digest(input string tag);
        n_checks++;
        if ({h0, h1, h2, h3, h4} !== 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d) begin
            n_fail++; $display("FAIL %s: got %h expected a9993e364706816aba3e25717850c26c9cd0d89d", tag, {h0, h1, h2, h3, h4});
        end
    endtask

    task automatic test_reset;
        {reset, start, first_block, msg_valid, msg_word} = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        repeat (3) @(negedge clk);
        reset = 0;
        n_checks++;
        if ({msg_ready, feed, next, busy, done} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 00000", {msg_ready, feed, next, busy, done}); end
        n_checks++;
        if (w !== 0 || k !== 0 || fsel !== 0) begin n_fail++; $display("FAIL reset_wkf: w %h k %h fsel %0d expected 0", w, k, fsel); end
        n_checks++;
        if ({h0, h1, h2, h3, h4} !== 160'b0) begin n_fail++; $display("FAIL reset_h: got %h expected 0", {h0, h1, h2, h3, h4}); end
        mh = '{default: 32'h0};
    endtask

    task automatic test_abc;
        set_abc();
        run_block(1, 0, -1, 0, 99);
        check_abc_digest("abc_digest");
    endtask

    task automatic test_two_block;
        blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        run_block(1, 0, -1, 0, 99);
        blk = '{default: 32'h0};
        blk[15] = 32'h000001c0;
        run_block(0, 0, -1, 0, 99);
        n_checks++;
        if ({h0, h1, h2, h3, h4} !== 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1) begin
            n_fail++; $display("FAIL two_block_digest: got %h expected 84983e441c3bd26ebaae4aa1f95129e5e54670f1", {h0, h1, h2, h3, h4});
        end
    endtask

    task automatic test_stall;
        set_abc();
        run_block(1, 1, -1, 0, 114);
        check_abc_digest("stall_digest");
    endtask

    task automatic test_reset_mid;
        set_abc();
        run_block(1, 0, 40, 0, 0);
        set_abc();
        run_block(1, 0, -1, 0, 99);
        check_abc_digest("rerun_digest");
    endtask

    task automatic test_ignored;
        repeat (3) begin
            @(negedge clk); msg_valid = 1; msg_word = $urandom;
            n_checks++;
            if (busy !== 0 || msg_ready !== 0 || {h0, h1, h2, h3, h4} !== {mh[0], mh[1], mh[2], mh[3], mh[4]}) begin
                n_fail++; $display("FAIL idle_msg_valid: busy %b ready %b h %h expected 0 0 %h", busy, msg_ready,
                    {h0, h1, h2, h3, h4}, {mh[0], mh[1], mh[2], mh[3], mh[4]});
            end
        end
        @(negedge clk); msg_valid = 0;
        n_checks++;
        if (busy !== 0) begin n_fail++; $display("FAIL idle_after_pulse: busy %b expected 0", busy); end
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        run_block(0, 0, -1, 1, 99);
    endtask

    task automatic test_random;
        int st;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            st = $urandom_range(2);
            run_block(n == 0 || $urandom_range(1) == 1, st, -1, 0, st == 0 ? 99 : st == 1 ? 114 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_two_block();
        test_stall();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule
